fdtd_sweep_engine: RTL and testbench
====================================

// Module: fdtd_sweep_engine
// PURPOSE
//  Per-timestep FDTD sweep controller and update datapath feeding the boundary PE.
//  Sweeps node addresses and streams Vn from the boundary PE's voltage M10K (out_n) and Vn-1 from a history M10K.
//  Computes Vn+1 per node and returns it on Vn1/Vn1_addr with the starting_write/finishing_fdtd framing the boundary PE consumes.
//  1D wave update: Vn1[i] = 2*Vn[i] - Vnm1[i] + rho*(Vn[i-1] + Vn[i+1] - 2*Vn[i]).
// PARAMETERS
//  NODES  110  nodes per sweep, addresses 0..NODES-1
//  DW     27   data width, signed Q1.26
//  AW     7    address width
//  FRAC   26   fractional bits of data and rho
// PORTS
//  clk             in   1   single clock
//  rst             in   1   synchronous, active-high reset
//  start           in   1   1-cycle pulse; begins one timestep sweep when idle
//  rho             in   DW  signed Q1.26 Courant coefficient; sampled on accepted start
//  out_n           in   DW  Vn read data from boundary PE, 1-cycle read latency
//  n_addr          out  AW  to boundary PE; its memory read address is n_addr-2
//  vnm1_addr       out  AW  read address of the Vn-1 history M10K
//  vnm1_q          in   DW  Vn-1 read data, 1-cycle read latency
//  Vn1             out  DW  computed Vn+1
//  Vn1_addr        out  AW  node index of Vn1
//  starting_write  out  1   high exactly in the cycles where Vn1/Vn1_addr are valid
//  finishing_fdtd  out  1   1-cycle pulse the cycle after the last valid Vn1
//  computing_on    out  1   high from accepted start through the finishing_fdtd cycle
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0: n_addr, vnm1_addr, Vn1, Vn1_addr, starting_write, finishing_fdtd, computing_on.
//  Reset is also cleared mid-sweep: outputs are 0 the cycle after rst, with no partial finishing_fdtd.
//  FSM states:
//   IDLE --start--> RUN; the start cycle is cycle 0; rho is latched.
//   RUN: cycles 1..NODES drive n_addr = k+2 (k = 0..NODES-1), so the Vn read address is k.
//   RUN -> DRAIN after k = NODES-1.
//   DRAIN: lasts until the last Vn1 is emitted.
//   DRAIN -> DONE: finishing_fdtd=1 for one cycle.
//   DONE -> IDLE.
//  start outside IDLE is ignored; there is no queuing.
//  Vn for node k arrives at cycle k+2. It shifts through a 3-entry window (left, centre, right).
//  Node j is computed at cycle j+3, when node j+1 arrives. For j = NODES-1, a zero is injected as right at cycle NODES+2.
//  Left of node 0 and right of node NODES-1 are treated as 0.
//  vnm1_addr = j is driven at cycle j+2, so vnm1_q aligns with centre j at cycle j+3.
//  Result is registered: Vn1/Vn1_addr for node j are valid at cycle j+4.
//  Nodes 0..NODES-1 therefore occupy cycles 4..NODES+3 with starting_write=1. finishing_fdtd is high at cycle NODES+4.
//  computing_on = 1 for cycles 0..NODES+4.
//  n_addr holds its last value during DRAIN/DONE and returns to 0 in IDLE.
//  Arithmetic, all signed:
//   lap = L + R - 2C, 29 bits.
//   prod = rho*lap, 56 bits; scaled = prod >>> FRAC (arithmetic, truncate toward -inf).
//   sum = 2C - Vnm1 + scaled, computed at >= 31 bits.
//   Vn1 saturates to [0x4000000 (-1.0), 0x3FFFFFF (~+1.0)]; no wrap.
//  Address arithmetic is modulo 2^AW. NODES <= 2^AW - 2 keeps n_addr non-wrapping.
// TESTING
//  T1 zeros: Vn=Vnm1=0, rho=0x1000000 -> Vn1=0 at addrs 0..109 on cycles 4..113, finishing_fdtd pulse at cycle 114.
//  T2 impulse: Vn[50]=0x2000000, rest 0, Vnm1=0, rho=0x1000000 -> Vn1[50]=0x3000000, Vn1[49]=Vn1[51]=0x0800000, all others 0.
//  T3 edges: Vn[0]=Vn[109]=0x2000000, rest 0, rho=0x1000000 -> Vn1[0]=Vn1[109]=0x3000000, Vn1[1]=Vn1[108]=0x0800000.
//  T4 saturation: Vn all 0x3FFFFFF, Vnm1=0, rho=0 -> all Vn1=0x3FFFFFF. Vn all 0x4000000 -> all Vn1=0x4000000.
//  T5 control: start at cycle 30 of a sweep is ignored. rst at cycle 50 -> outputs 0 at 51, no finishing_fdtd.
//   A new start after reset gives a full T1 timing sweep.
//  T6 back-to-back: start on the cycle after DONE -> accepted; second sweep timing identical to T1.

Source files
------------

// File: rtl/fdtd_sweep_engine.sv
// One-timestep 1D FDTD sweep. Streams Vn and Vn-1 from their memories and returns
// the saturated Vn+1 for each node, framed for the boundary PE.
module fdtd_sweep_engine #(
  parameter int NODES = 110,
  parameter int DW    = 27,
  parameter int AW    = 7,
  parameter int FRAC  = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] rho,
  input  logic [DW-1:0] out_n,
  output logic [AW-1:0] n_addr,
  output logic [AW-1:0] vnm1_addr,
  input  logic [DW-1:0] vnm1_q,
  output logic [DW-1:0] Vn1,
  output logic [AW-1:0] Vn1_addr,
  output logic          starting_write,
  output logic          finishing_fdtd,
  output logic          computing_on,
  output logic [1:0]    o_dbg_state
);
  // Handshake: start is a single-cycle request, accepted only in IDLE; no ready is
  // returned and starts seen outside IDLE are dropped. starting_write is a valid
  // strobe with no back-pressure: Vn1/Vn1_addr must be consumed in that cycle.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = $clog2(NODES + 6);
  localparam int LW = DW + 2;
  localparam int PW = DW + LW;
  localparam int SW = DW + 5;

  localparam logic [CW-1:0] C_FIRST_IN   = CW'(2);
  localparam logic [CW-1:0] C_LAST_IN    = CW'(NODES + 1);
  localparam logic [CW-1:0] C_FIRST_CALC = CW'(3);
  localparam logic [CW-1:0] C_LAST_CALC  = CW'(NODES + 2);
  localparam logic [CW-1:0] C_RUN_END    = CW'(NODES);
  localparam logic [CW-1:0] C_DRAIN_END  = CW'(NODES + 3);

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cyc;
  logic signed [DW-1:0] r_rho;
  logic signed [DW-1:0] r_l;
  logic signed [DW-1:0] r_c;
  logic [AW-1:0]        r_n_addr;
  logic [AW-1:0]        r_vnm1_addr;
  logic [DW-1:0]        r_vn1;
  logic [AW-1:0]        r_vn1_addr;
  logic                 r_sw;
  logic                 r_ff;

  logic                 w_active;
  logic                 w_shift_en;
  logic                 w_calc_en;
  logic signed [DW-1:0] w_r;
  logic signed [LW-1:0] w_l_x;
  logic signed [LW-1:0] w_r_x;
  logic signed [LW-1:0] w_c2_x;
  logic signed [LW-1:0] w_lap;
  logic signed [PW-1:0] w_rho_p;
  logic signed [PW-1:0] w_lap_p;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_prod_sh;
  logic signed [SW-1:0] w_scaled;
  logic signed [SW-1:0] w_sum;
  logic                 w_ovf;
  logic [DW-1:0]        w_sat;

  assign w_active   = (r_state != S_IDLE);
  assign w_shift_en = w_active && (r_cyc >= C_FIRST_IN) && (r_cyc <= C_LAST_IN);
  assign w_calc_en  = w_active && (r_cyc >= C_FIRST_CALC) && (r_cyc <= C_LAST_CALC);

  // The last node has no right neighbour; the memory data in that slot is stale.
  assign w_r = (r_cyc == C_LAST_CALC) ? '0 : $signed(out_n);

  assign w_l_x  = {{2{r_l[DW-1]}}, r_l};
  assign w_r_x  = {{2{w_r[DW-1]}}, w_r};
  assign w_c2_x = {r_c[DW-1], r_c, 1'b0};
  assign w_lap  = w_l_x + w_r_x - w_c2_x;

  assign w_rho_p   = {{LW{r_rho[DW-1]}}, r_rho};
  assign w_lap_p   = {{DW{w_lap[LW-1]}}, w_lap};
  assign w_prod    = w_rho_p * w_lap_p;
  assign w_prod_sh = w_prod >>> FRAC;
  assign w_scaled  = w_prod_sh[SW-1:0];

  assign w_sum = {{(SW-DW-1){r_c[DW-1]}}, r_c, 1'b0}
               - {{(SW-DW){vnm1_q[DW-1]}}, vnm1_q}
               + w_scaled;

  // Any disagreement among the bits above the result's sign bit means out of range.
  assign w_ovf = !((&w_sum[SW-1:DW-1]) || (~|w_sum[SW-1:DW-1]));
  assign w_sat = w_ovf ? (w_sum[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                       : w_sum[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_rho       <= '0;
      r_l         <= '0;
      r_c         <= '0;
      r_n_addr    <= '0;
      r_vnm1_addr <= '0;
      r_vn1       <= '0;
      r_vn1_addr  <= '0;
      r_sw        <= 1'b0;
      r_ff        <= 1'b0;
    end else begin
      r_sw <= w_calc_en;
      r_ff <= 1'b0;
      if (w_calc_en) begin
        r_vn1      <= w_sat;
        r_vn1_addr <= AW'(r_cyc - C_FIRST_CALC);
      end
      if (w_shift_en) begin
        r_l <= r_c;
        r_c <= out_n;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_cyc       <= CW'(1);
            r_rho       <= rho;
            r_l         <= '0;
            r_c         <= '0;
            r_n_addr    <= AW'(2);
            r_vnm1_addr <= '0;
          end
        end
        S_RUN: begin
          r_cyc       <= r_cyc + CW'(1);
          r_vnm1_addr <= r_n_addr - AW'(2);
          if (r_cyc == C_RUN_END) begin
            r_state <= S_DRAIN;
          end else begin
            r_n_addr <= r_n_addr + AW'(1);
          end
        end
        S_DRAIN: begin
          r_cyc <= r_cyc + CW'(1);
          if (r_cyc == C_DRAIN_END) begin
            r_state <= S_DONE;
            r_ff    <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cyc       <= '0;
          r_n_addr    <= '0;
          r_vnm1_addr <= '0;
        end
      endcase
    end
  end

  assign n_addr         = r_n_addr;
  assign vnm1_addr      = r_vnm1_addr;
  assign Vn1            = r_vn1;
  assign Vn1_addr       = r_vn1_addr;
  assign starting_write = r_sw;
  assign finishing_fdtd = r_ff;
  assign computing_on   = w_active || start;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fdtd_sweep_engine.sv
// Bench for fdtd_sweep_engine: memory models for Vn/Vn-1, a reference update model
// feeding an expected queue, per-cycle framing checks and a table of sweeps.
module tb_fdtd_sweep_engine;
  localparam int NODES = 110;
  localparam int DW    = 27;
  localparam int AW    = 7;
  localparam int FRAC  = 26;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [DW-1:0] rho;
  logic [DW-1:0] out_n;
  logic [DW-1:0] vnm1_q;
  logic [AW-1:0] n_addr;
  logic [AW-1:0] vnm1_addr;
  logic [DW-1:0] vn1;
  logic [AW-1:0] vn1_addr;
  logic sw, ff, co;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  fdtd_sweep_engine #(.NODES(NODES), .DW(DW), .AW(AW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .rho(rho),
    .out_n(out_n), .n_addr(n_addr), .vnm1_addr(vnm1_addr), .vnm1_q(vnm1_q),
    .Vn1(vn1), .Vn1_addr(vn1_addr), .starting_write(sw),
    .finishing_fdtd(ff), .computing_on(co), .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  bit mon_en  = 1'b0;
  int abort_rel = 1 << 30;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0] vn_mem   [NODES];
  logic [DW-1:0] vnm1_mem [NODES];
  logic [DW-1:0] got_mem  [NODES];

  // Memories with one cycle of read latency; boundary PE reads at n_addr-2.
  logic [AW-1:0] rd_n;
  assign rd_n = n_addr - 7'd2;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    out_n  <= (int'(rd_n) < NODES) ? vn_mem[rd_n] : '0;
    vnm1_q <= (int'(vnm1_addr) < NODES) ? vnm1_mem[vnm1_addr] : '0;
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [DW-1:0] model(input int j, input logic [DW-1:0] r);
    longint c, l, rt, m, lap, prod, sc, s;
    c    = sx(vn_mem[j]);
    l    = (j > 0) ? sx(vn_mem[j-1]) : 0;
    rt   = (j < NODES-1) ? sx(vn_mem[j+1]) : 0;
    m    = sx(vnm1_mem[j]);
    lap  = l + rt - 2 * c;
    prod = sx(r) * lap;
    sc   = prod >>> FRAC;
    s    = 2 * c - m + sc;
    if (s > 64'sd67108863) s = 64'sd67108863;
    if (s < -64'sd67108864) s = -64'sd67108864;
    return s[DW-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_pattern(input int pat);
    for (int k = 0; k < NODES; k++) begin
      vnm1_mem[k] = '0;
      got_mem[k]  = '0;
      case (pat)
        1: vn_mem[k] = (k == 50) ? 27'h2000000 : '0;
        2: vn_mem[k] = (k == 0 || k == NODES-1) ? 27'h2000000 : '0;
        3: vn_mem[k] = 27'h3FFFFFF;
        4: vn_mem[k] = 27'h4000000;
        5: begin
          vn_mem[k]   = DW'($urandom);
          vnm1_mem[k] = DW'($urandom);
        end
        6: vn_mem[k] = (k == 40) ? 27'h2000000 : '0;
        default: vn_mem[k] = '0;
      endcase
    end
  endtask

  // Called just after a rising edge; that cycle becomes cycle 0 of the sweep.
  task automatic start_sweep(input logic [DW-1:0] r);
    start = 1'b1;
    rho   = r;
    t0    = cyc;
    for (int j = 0; j < NODES; j++) exp_q.push_back({AW'(j), model(j, r)});
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rho   = DW'($urandom);
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    int rel;
    logic [AW+DW-1:0] e;
    if (mon_en) begin
      rel = cyc - t0;
      if (rel > abort_rel) begin
        chk("abort_n_addr", n_addr, 0);
        chk("abort_vnm1_addr", vnm1_addr, 0);
        chk("abort_vn1", vn1, 0);
        chk("abort_vn1_addr", vn1_addr, 0);
        chk("abort_starting_write", sw, 0);
        chk("abort_finishing_fdtd", ff, 0);
        chk("abort_computing_on", co, 0);
      end else begin
        chk("starting_write", sw, (rel >= 4 && rel <= NODES+3));
        chk("finishing_fdtd", ff, (rel == NODES+4));
        chk("computing_on", co, (rel <= NODES+4));
        if (rel == 0 || rel > NODES+4) chk("n_addr_idle", n_addr, 0);
        else if (rel <= NODES)         chk("n_addr_run", n_addr, rel + 1);
        else                           chk("n_addr_hold", n_addr, NODES + 1);
        if (rel >= 2 && rel <= NODES+1) chk("vnm1_addr", vnm1_addr, rel - 2);
        if (rel > NODES+4) chk("vnm1_addr_idle", vnm1_addr, 0);
        if (sw) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_vn1", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("vn1_addr", vn1_addr, e[AW+DW-1:DW]);
            chk("vn1_data", vn1, e[DW-1:0]);
          end
          if (int'(vn1_addr) < NODES) got_mem[vn1_addr] = vn1;
        end
        if (rel == NODES+4) chk("queue_drained", exp_q.size(), 0);
      end
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    int pat;
    logic [DW-1:0] rho;
    int na; logic [DW-1:0] ea;
    int nb; logic [DW-1:0] eb;
    int nc; logic [DW-1:0] ec;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [DW-1:0] r;
    vecs[0] = '{0, 27'h1000000, 0,  27'h0,       109, 27'h0,       55,  27'h0};
    vecs[1] = '{1, 27'h1000000, 50, 27'h3000000, 49,  27'h0800000, 51,  27'h0800000};
    vecs[2] = '{2, 27'h1000000, 0,  27'h3000000, 109, 27'h3000000, 108, 27'h0800000};
    vecs[3] = '{3, 27'h0,       0,  27'h3FFFFFF, 55,  27'h3FFFFFF, 109, 27'h3FFFFFF};
    vecs[4] = '{4, 27'h0,       0,  27'h4000000, 55,  27'h4000000, 109, 27'h4000000};
    vecs[5] = '{5, 27'h0,       -1, 27'h0,       -1,  27'h0,       -1,  27'h0};
    vecs[6] = '{5, 27'h0,       -1, 27'h0,       -1,  27'h0,       -1,  27'h0};

    rst = 1'b1; start = 1'b0; rho = '0;
    load_pattern(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_n_addr", n_addr, 0);
    chk("rst_vnm1_addr", vnm1_addr, 0);
    chk("rst_vn1", vn1, 0);
    chk("rst_vn1_addr", vn1_addr, 0);
    chk("rst_starting_write", sw, 0);
    chk("rst_finishing_fdtd", ff, 0);
    chk("rst_computing_on", co, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load_pattern(vecs[i].pat);
      r = (vecs[i].pat == 5) ? DW'($urandom) : vecs[i].rho;
      @(posedge clk); #1;
      start_sweep(r);
      wait_rel(NODES + 5);
      if (vecs[i].na >= 0) begin
        chk($sformatf("tbl%0d_node%0d", i, vecs[i].na), got_mem[vecs[i].na], vecs[i].ea);
        chk($sformatf("tbl%0d_node%0d", i, vecs[i].nb), got_mem[vecs[i].nb], vecs[i].eb);
        chk($sformatf("tbl%0d_node%0d", i, vecs[i].nc), got_mem[vecs[i].nc], vecs[i].ec);
      end
    end

    // Back-to-back: start in the cycle right after DONE.
    load_pattern(0);
    start_sweep(27'h1000000);
    wait_rel(NODES + 5);

    // Ignored start mid-sweep, then reset mid-sweep.
    load_pattern(6);
    @(posedge clk); #1;
    start_sweep(27'h1000000);
    wait_rel(30);
    start = 1'b1; rho = 27'h0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_rel(50);
    abort_rel = 50;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_rel(56);
    mon_en = 1'b0;
    chk("ignored_start_node41", got_mem[41], 27'h0800000);
    chk("ignored_start_node40", got_mem[40], 27'h3000000);
    exp_q.delete();
    abort_rel = 1 << 30;

    // Full sweep after reset.
    load_pattern(0);
    @(posedge clk); #1;
    start_sweep(27'h1000000);
    wait_rel(NODES + 8);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
